// File: rtl/rbs_pkg.sv
// Shared types and defaults for the registered ripple-borrow subtractor.
// Holds the FSM state encoding, default widths and the chunk-index width helper.
package rbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RBS_WIDTH = 32;
  localparam int RBS_CHUNK = 8;

  // Width of the chunk index; never zero so a single-chunk build still has a register.
  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/rbs_chunk.sv
// Combinational CHUNK-bit ripple-borrow subtractor: diff = x - y - bin, bout = borrow out.
// Latency: none (purely combinational); backpressure: not applicable.
module rbs_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic [CHUNK:0] brw;

  assign brw[0] = bin;

  // Full-subtractor per bit: borrow when x<y, or x==y with an incoming borrow.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign diff[i]  = x[i] ^ y[i] ^ brw[i];
    assign brw[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
  end

  assign bout = brw[CHUNK];

endmodule

// File: rtl/rbs_seq_clk.sv
// Multi-cycle subtractor d = a - b - bi, CHUNK bits per clock; optional RBS_SIGNED_OVF_EN adds ov.
// Latency: out_valid NUM edges after accept; backpressure: result held in DONE until out_ready, one op in flight.
module rbs_seq_clk
  import rbs_pkg::*;
#(
  parameter int WIDTH = RBS_WIDTH,
  parameter int CHUNK = RBS_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef RBS_SIGNED_OVF_EN
  ,
  output logic             ov
`endif
);

  localparam int NUM = WIDTH / CHUNK;
  localparam int IW  = idx_width(NUM);
  localparam logic [IW-1:0] LAST = IW'(NUM - 1);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             brw;

  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK-1:0] y_chunk;
  logic [CHUNK-1:0] diff;
  logic             bout;

  assign x_chunk = a_q[int'(idx)*CHUNK +: CHUNK];
  assign y_chunk = b_q[int'(idx)*CHUNK +: CHUNK];

  // One shared chunk subtractor, time-multiplexed across the operand slices.
  rbs_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (x_chunk),
    .y    (y_chunk),
    .bin  (brw),
    .diff (diff),
    .bout (bout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      d     <= '0;
      bo    <= 1'b0;
      brw   <= 1'b0;
      idx   <= '0;
`ifdef RBS_SIGNED_OVF_EN
      ov    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            brw   <= bi;
            idx   <= '0;
            d     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          d[int'(idx)*CHUNK +: CHUNK] <= diff;
          brw <= bout;
          if (idx == LAST) begin
            idx   <= '0;
            bo    <= bout;
            state <= DONE;
`ifdef RBS_SIGNED_OVF_EN
            // The top chunk is being written this edge, so its MSB comes from diff.
            ov    <= (a_q[MSB] != b_q[MSB]) && (diff[CHUNK-1] != a_q[MSB]);
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbs_seq_clk.sv
// Randomized and directed bench for rbs_seq_clk against an arithmetic reference model.
module tb_rbs_seq_clk;

  localparam int W   = 32;
  localparam int C   = 8;
  localparam int NUM = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bi = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;
  logic         bo;
`ifdef RBS_SIGNED_OVF_EN
  logic         ov;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rbs_seq_clk #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef RBS_SIGNED_OVF_EN
    ,
    .ov        (ov)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the (W+1)-bit difference; its top bit is set exactly when a < b + bi.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic rbi);
    logic [W:0] wa, wb, wbi;
    wa  = {1'b0, ra};
    wb  = {1'b0, rb};
    wbi = '0;
    wbi[0] = rbi;
    return wa - wb - wbi;
  endfunction

  // Issues one operation from IDLE, checks latency/result, holds back-pressure, then drains.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tbi,
                        input int hold);
    logic [W:0]   r;
    logic [W-1:0] d0;
    logic         bo0;
    int           lat;
    int           rdy_hi;
    int           bp_bad;
    r = ref_sub(ta, tb_op, tbi);
    a = ta; b = tb_op; bi = tbi; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Operands are latched; scramble the inputs while the op is in flight.
    in_valid = 1'($urandom_range(0, 1));
    a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
    lat = 0; rdy_hi = 0; bp_bad = 0;
    while (!out_valid && lat < 4 * NUM) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(NUM));
    chk("d", 64'(d), 64'(r[W-1:0]));
    chk("bo", 64'(bo), 64'(r[W]));
`ifdef RBS_SIGNED_OVF_EN
    chk("ov", 64'(ov), 64'((ta[W-1] != tb_op[W-1]) && (r[W-1] != ta[W-1])));
`endif
    d0 = d; bo0 = bo;
    for (int i = 0; i < hold; i++) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1));
      if (d !== d0 || bo !== bo0 || !out_valid || in_ready) bp_bad++;
    end
    if (hold > 0) chk("hold_stable", 64'(bp_bad), 64'd0);
    chk("in_ready_busy", 64'(rdy_hi), 64'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_drain", 64'(in_ready), 64'd1);
    chk("out_valid_after_drain", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_bo", 64'(bo), 64'd0);
`ifdef RBS_SIGNED_OVF_EN
    chk("rst_ov", 64'(ov), 64'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_op(32'd38297, 32'd126625, 1'b0, 0);
    run_op(32'd126625, 32'd38297, 1'b0, 0);
    run_op(32'd0, 32'd0, 1'b1, 1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd126625, 32'd38297, 1'b0, 5);
`ifdef RBS_SIGNED_OVF_EN
    run_op(32'h8000_0000, 32'd1, 1'b0, 0);
    run_op(32'd5, 32'd3, 1'b0, 0);
`endif

    // Abort in the second RUN cycle after a result that left bo=1.
    run_op(32'd0, 32'd0, 1'b1, 0);
    a = 32'h1234_5678; b = 32'h0000_0001; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_d", 64'(d), 64'd0);
    chk("abort_bo", 64'(bo), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    run_op(32'd100, 32'd100, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      ra = $urandom; rb = $urandom;
      case (sel)
        1: begin ra = ($urandom_range(0, 1) != 0) ? '1 : '0; rb = ($urandom_range(0, 1) != 0) ? '1 : '0; end
        2: rb = ra;
        3: begin ra = 32'h1 << ($urandom_range(0, 3) * C); rb = ra + 32'($urandom_range(0, 2)) - 32'd1; end
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
